// File: rtl/swipt_pwm_gen_pkg.sv
// Shared constants and state type for the SWIPT half-bridge PWM path.
package swipt_pwm_gen_pkg;

    localparam int PWM_PERIOD_DEF = 500;
    localparam int DW_DEF         = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/swipt_deadtime_ins.sv
// Dead-time inserter for one bridge leg: splits raw into a
// complementary hi/lo pair with a guard gap after every raw edge.
module swipt_deadtime_ins #(
    parameter int DEADTIME = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_raw,
    output logic o_hi,
    output logic o_lo
);

    localparam int CW = $clog2(DEADTIME + 1);
    localparam logic [CW-1:0] DT_MAX = CW'(DEADTIME);

    logic          r_run_q;
    logic          r_raw_q;
    logic [CW-1:0] r_dt_cnt;
    logic          r_hi;
    logic          r_lo;
    logic [CW-1:0] w_dt;
    logic          w_settled;

    // Entry into run and any raw edge restart the guard interval.
    always_comb begin
        w_dt = '0;
        if (i_run && r_run_q && (i_raw == r_raw_q)) begin
            w_dt = (r_dt_cnt == DT_MAX) ? DT_MAX : r_dt_cnt + 1'b1;
        end
    end

    assign w_settled = i_run & (w_dt == DT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_q  <= 1'b0;
            r_raw_q  <= 1'b0;
            r_dt_cnt <= '0;
            r_hi     <= 1'b0;
            r_lo     <= 1'b0;
        end else begin
            r_run_q  <= i_run;
            r_raw_q  <= i_raw;
            r_dt_cnt <= w_dt;
            r_hi     <= w_settled & i_raw;
            r_lo     <= w_settled & ~i_raw;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/swipt_pwm_gen.sv
// Fixed-period complementary PWM with double-buffered duty and dead time.
// Optional SWIPT_PWM_SLEW_EN limits each duty reload step to SLEW counts.
import swipt_pwm_gen_pkg::*;

module swipt_pwm_gen #(
    parameter int DW       = DW_DEF,
    parameter int PERIOD   = PWM_PERIOD_DEF,
    parameter int DEADTIME = 8
`ifdef SWIPT_PWM_SLEW_EN
    ,
    parameter int SLEW     = 50
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] duty_in,
    output logic          pwm_hi,
    output logic          pwm_lo,
    output logic          period_start,
    output logic [DW-1:0] duty_applied,
    output logic          clamp_flag
);

    localparam logic [DW-1:0] P_MAX  = DW'(PERIOD);
    localparam logic [DW-1:0] P_LAST = DW'(PERIOD - 1);

    pwm_state_e    r_state;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_shadow;
    logic          r_clamp;
    logic          r_ps;

    logic          w_run;
    logic          w_raw;
    logic          w_entry;
    logic          w_load;
    logic          w_over;
    logic [DW-1:0] w_target;
    logic [DW-1:0] w_next;

    assign w_run    = (r_state == RUN) & en;
    assign w_raw    = w_run & (r_cnt < r_shadow);
    assign w_entry  = (r_state == IDLE) & en;
    assign w_load   = w_entry | (w_run & (r_cnt == P_LAST));
    assign w_over   = duty_in > P_MAX;
    assign w_target = w_over ? P_MAX : duty_in;

`ifdef SWIPT_PWM_SLEW_EN
    localparam logic [DW-1:0] SL = DW'(SLEW);
    logic [DW-1:0] w_base;

    // A fresh run always ramps up from zero, not from the stale shadow.
    assign w_base = w_entry ? '0 : r_shadow;

    always_comb begin
        w_next = w_target;
        if (w_target > w_base) begin
            if (w_target - w_base > SL) w_next = w_base + SL;
        end else if (w_base - w_target > SL) begin
            w_next = w_base - SL;
        end
    end
`else
    assign w_next = w_target;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_clamp  <= 1'b0;
            r_ps     <= 1'b0;
        end else begin
            r_ps <= w_run & (r_cnt == '0);
            if (w_load) begin
                r_shadow <= w_next;
                r_clamp  <= w_over;
            end
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (en) r_state <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= (r_cnt == P_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    swipt_deadtime_ins #(
        .DEADTIME (DEADTIME)
    ) u_dt (
        .clk   (clk),
        .rst   (rst),
        .i_run (w_run),
        .i_raw (w_raw),
        .o_hi  (pwm_hi),
        .o_lo  (pwm_lo)
    );

    assign period_start = r_ps;
    assign duty_applied = r_shadow;
    assign clamp_flag   = r_clamp;

endmodule

// File: tb/tb_swipt_pwm_gen.sv
// Randomised and directed bench for swipt_pwm_gen against a
// window-based behavioural model of the PWM pair.
module tb_swipt_pwm_gen;

    localparam int DW = 12;
    localparam int P  = 500;
    localparam int DT = 8;
`ifdef SWIPT_PWM_SLEW_EN
    localparam int SLEW = 50;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [DW-1:0] duty_in = '0;
    logic          pwm_hi;
    logic          pwm_lo;
    logic          period_start;
    logic [DW-1:0] duty_applied;
    logic          clamp_flag;

    swipt_pwm_gen #(
        .DW       (DW),
        .PERIOD   (P),
        .DEADTIME (DT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .duty_in      (duty_in),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start),
        .duty_applied (duty_applied),
        .clamp_flag   (clamp_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int inv_bad = 0;

    // Model state: position in period and the duty in force.
    bit   m_run = 0;
    int   m_pos = 0;
    int   m_shadow = 0;
    bit   m_clamp = 0;
    bit   qh [0:DT];
    bit   rh [0:DT];
    logic [15:0] m_exp = '0;

    wire [15:0] w_got = {pwm_hi, pwm_lo, period_start, clamp_flag, duty_applied};

    always @(negedge clk) begin
        if (pwm_hi === 1'b1 && pwm_lo === 1'b1) inv_bad++;
    end

    // A gate output is on only if the last DT+1 cycles were all
    // running with the same raw level (DT guard cycles after an edge).
    task automatic tick();
        bit q, r, all_q, same, e_hi, e_lo, e_ps;
        int tgt;
`ifdef SWIPT_PWM_SLEW_EN
        int base;
`endif
        bit ld, entry;
        q = m_run && en;
        r = q && (m_pos < m_shadow);
        for (int i = DT; i > 0; i--) begin
            qh[i] = qh[i-1];
            rh[i] = rh[i-1];
        end
        qh[0] = q;
        rh[0] = r;
        all_q = 1;
        same  = 1;
        for (int i = 0; i <= DT; i++) begin
            all_q &= qh[i];
            same  &= (rh[i] == r);
        end
        e_hi = all_q && same && r;
        e_lo = all_q && same && !r;
        e_ps = q && (m_pos == 0);
        ld = 0;
        entry = 0;
        if (rst) begin
            m_run = 0; m_pos = 0; m_shadow = 0; m_clamp = 0;
            e_hi = 0; e_lo = 0; e_ps = 0;
            for (int i = 0; i <= DT; i++) begin
                qh[i] = 0;
                rh[i] = 0;
            end
        end else if (!m_run) begin
            if (en) begin
                m_run = 1; m_pos = 0; ld = 1; entry = 1;
            end
        end else if (!en) begin
            m_run = 0; m_pos = 0;
        end else if (m_pos == P - 1) begin
            m_pos = 0; ld = 1;
        end else begin
            m_pos++;
        end
        if (ld) begin
            m_clamp = (int'(duty_in) > P);
            tgt = m_clamp ? P : int'(duty_in);
`ifdef SWIPT_PWM_SLEW_EN
            base = entry ? 0 : m_shadow;
            if (tgt > base + SLEW) tgt = base + SLEW;
            else if (tgt < base - SLEW) tgt = base - SLEW;
`endif
            m_shadow = tgt;
        end
        m_exp = {e_hi, e_lo, e_ps, m_clamp, 12'(m_shadow)};
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; duty_in = 12'd77;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (w_got !== 16'h0) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=0000", cyc, w_got);
            end
        end
        en = 1;
        tick();
        total++;
        if (w_got !== 16'h0) begin
            bad++;
            $display("FAIL reset_en cyc=%0d got=%h want=0000", cyc, w_got);
        end
        en = 0;
    endtask

    task automatic test_basic();
        int nh, nl, nps;
        bit seen;
        rst = 0; duty_in = 250; en = 1;
        nh = 0; nl = 0; nps = 0; seen = 0;
        for (int i = 0; i < 1600; i++) begin
            tick();
            total++;
            if (w_got !== m_exp) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%h want=%h", cyc, w_got, m_exp);
            end
            if (period_start) begin
                nps++;
                if (seen) begin
                    total++;
                    if (nh !== 242 || nl !== 242) begin
                        bad++;
                        $display("FAIL basic_width hi=%0d lo=%0d want 242/242", nh, nl);
                    end
                end
                seen = 1; nh = 0; nl = 0;
            end
            nh += int'(pwm_hi);
            nl += int'(pwm_lo);
        end
        total++;
        if (nps !== 4) begin
            bad++;
            $display("FAIL basic_ps count=%0d want 4", nps);
        end
    endtask

    task automatic test_clamp();
        int nh, nl;
        duty_in = 700;
        for (int i = 0; i < 1000; i++) begin
            tick();
            total++;
            if (w_got !== m_exp) begin
                bad++;
                $display("FAIL clamp cyc=%0d got=%h want=%h", cyc, w_got, m_exp);
            end
        end
        nh = 0; nl = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            nh += int'(pwm_hi);
            nl += int'(pwm_lo);
        end
        total++;
        if (nh !== 500 || nl !== 0) begin
            bad++;
            $display("FAIL clamp_width hi=%0d lo=%0d want 500/0", nh, nl);
        end
        total++;
        if (duty_applied !== 12'd500 || clamp_flag !== 1'b1) begin
            bad++;
            $display("FAIL clamp_val duty=%0d flag=%b want 500/1", duty_applied, clamp_flag);
        end
    endtask

    task automatic test_zero_small();
        int nh, nl;
        bit seen;
        duty_in = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            total++;
            if (w_got !== m_exp) begin
                bad++;
                $display("FAIL zero cyc=%0d got=%h want=%h", cyc, w_got, m_exp);
            end
        end
        nl = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            nl += int'(pwm_lo);
        end
        total++;
        if (nl !== 500 || clamp_flag !== 1'b0) begin
            bad++;
            $display("FAIL zero_lo lo=%0d flag=%b want 500/0", nl, clamp_flag);
        end
        duty_in = 5;
        nh = 0; nl = 0; seen = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            total++;
            if (w_got !== m_exp) begin
                bad++;
                $display("FAIL small cyc=%0d got=%h want=%h", cyc, w_got, m_exp);
            end
            if (period_start) begin
                if (seen) begin
                    total++;
                    if (nh !== 0 || nl !== 487) begin
                        bad++;
                        $display("FAIL small_width hi=%0d lo=%0d want 0/487", nh, nl);
                    end
                end
                seen = 1; nh = 0; nl = 0;
            end
            nh += int'(pwm_hi);
            nl += int'(pwm_lo);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 2000; i++) begin
            duty_in = ((i / 37) % 2 == 1) ? 12'd400 : 12'd100;
            tick();
            total++;
            if (w_got !== m_exp) begin
                bad++;
                $display("FAIL toggle cyc=%0d got=%h want=%h", cyc, w_got, m_exp);
            end
        end
    endtask

    task automatic test_abort();
        rst = 1; en = 0;
        tick();
        rst = 0; en = 1; duty_in = 300;
        tick();
        for (int i = 0; i < 600 && m_pos != 123; i++) tick();
        total++;
        if (m_pos != 123 || pwm_hi !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre pos=%0d hi=%b want 123/1", m_pos, pwm_hi);
        end
        rst = 1;
        tick();
        total++;
        if (w_got !== 16'h0) begin
            bad++;
            $display("FAIL abort_rst got=%h want=0000", w_got);
        end
        rst = 0;
        for (int j = 0; j < 9; j++) begin
            tick();
            total++;
            if (w_got !== m_exp || pwm_hi !== 1'b0 || pwm_lo !== 1'b0) begin
                bad++;
                $display("FAIL abort_reentry j=%0d got=%h want=%h", j, w_got, m_exp);
            end
        end
        tick();
        total++;
        if (pwm_hi !== 1'b1 || duty_applied !== 12'd300) begin
            bad++;
            $display("FAIL abort_first hi=%b duty=%0d want 1/300", pwm_hi, duty_applied);
        end
        for (int i = 0; i < 600 && m_pos != 123; i++) tick();
        en = 0;
        tick();
        total++;
        if (pwm_hi !== 1'b0 || pwm_lo !== 1'b0 || duty_applied !== 12'd300) begin
            bad++;
            $display("FAIL abort_en hi=%b lo=%b duty=%0d want 0/0/300", pwm_hi, pwm_lo, duty_applied);
        end
        duty_in = 200; en = 1;
        tick();
        total++;
        if (duty_applied !== 12'd200 || w_got !== m_exp) begin
            bad++;
            $display("FAIL abort_reload got=%h want=%h", w_got, m_exp);
        end
    endtask

`ifdef SWIPT_PWM_SLEW_EN
    task automatic test_slew();
        int k;
        logic [DW-1:0] prev;
        rst = 1; en = 0;
        tick();
        rst = 0; en = 1; duty_in = 0;
        tick();
        duty_in = 300;
        k = 0;
        prev = duty_applied;
        for (int i = 0; i < 3200; i++) begin
            tick();
            total++;
            if (w_got !== m_exp) begin
                bad++;
                $display("FAIL slew cyc=%0d got=%h want=%h", cyc, w_got, m_exp);
            end
            if (duty_applied !== prev) begin
                k++;
                total++;
                if (duty_applied !== 12'(50 * k)) begin
                    bad++;
                    $display("FAIL slew_step k=%0d got=%0d want=%0d", k, duty_applied, 50 * k);
                end
                prev = duty_applied;
            end
        end
        total++;
        if (k !== 6) begin
            bad++;
            $display("FAIL slew_count got=%0d want 6", k);
        end
    endtask
`endif

    task automatic test_random();
        int off;
        rst = 1; en = 0;
        tick();
        rst = 0; en = 1;
        off = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) duty_in = 12'($urandom_range(0, 700));
            if (off > 0) begin
                off--;
                en = (off == 0);
            end else if ($urandom_range(0, 999) == 0) begin
                off = $urandom_range(1, 20);
                en = 0;
            end
            rst = ($urandom_range(0, 2999) == 0);
            tick();
            total++;
            if (w_got !== m_exp) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, w_got, m_exp);
            end
        end
        rst = 0;
    endtask

    task automatic test_invariant();
        total++;
        if (inv_bad !== 0) begin
            bad++;
            $display("FAIL invariant overlap_cycles=%0d want 0", inv_bad);
        end
    endtask

    initial begin
        for (int i = 0; i <= DT; i++) begin
            qh[i] = 0;
            rh[i] = 0;
        end
        test_reset();
        test_basic();
        test_clamp();
        test_zero_small();
        test_toggle();
        test_abort();
`ifdef SWIPT_PWM_SLEW_EN
        test_slew();
`endif
        test_random();
        test_invariant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/swipt_pwm_gen.md
Name: swipt_pwm_gen

Overview:
- Downstream consumer of the duty-adjust stage's 12-bit duty word.
- Generates a fixed-period, complementary half-bridge PWM pair with programmable dead time.
- Duty is double-buffered: sampled only at period boundaries, so the glitchy mid-period duty changes produced by the data-modulation scheme never truncate a pulse.
- Sits between the duty-adjust stage and the SWIPT power-stage gate drivers.

Parameters:
- DW, 12, width of the duty and counter datapath.
- PERIOD, 500, PWM period in clk cycles; duty full scale (0x1F4).
- DEADTIME, 8, minimum cycles both outputs are low around every transition; must satisfy 1 <= DEADTIME < PERIOD/2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; driven from swiptAlive.
- duty_in  in  DW  requested high-time in cycles, from the duty-adjust stage.
- pwm_hi  out  1  high-side gate command.
- pwm_lo  out  1  low-side gate command.
- period_start  out  1  one-cycle pulse on the first cycle of every period.
- duty_applied  out  DW  shadow duty currently in force.
- clamp_flag  out  1  set when the loaded duty_in exceeded PERIOD.

Behaviour:
- Reset: rst=1 at a clk edge forces cnt=0, shadow=0, dt_cnt=0, state=IDLE. All outputs go to 0 on that edge. Reset overrides en, including mid-period and mid-dead-time.
- FSM has two states:
  - IDLE: outputs low, cnt held at 0. Moves to RUN when en=1.
  - RUN: moves to IDLE when en=0. Exit is immediate, same cycle, with no dead-time wind-down; both outputs go low on the next edge.
- Counter:
  - In RUN, cnt counts 0..PERIOD-1 and wraps.
  - Shadow load occurs on the IDLE->RUN transition and at cnt==PERIOD-1: shadow <= min(duty_in, PERIOD). The new value takes effect at cnt=0.
  - clamp_flag <= (duty_in > PERIOD) on each load; it holds until the next load.
- Raw waveform: raw = (cnt < shadow), evaluated only in RUN.
- Dead time:
  - dt_cnt resets to 0 on any raw transition and on IDLE->RUN entry. Otherwise it increments, saturating at DEADTIME.
  - pwm_hi = raw & (dt_cnt==DEADTIME).
  - pwm_lo = ~raw & (dt_cnt==DEADTIME).
  - Both outputs are registered, giving 1-cycle latency from cnt/raw.
  - pwm_hi & pwm_lo is never 1. This is a hard invariant.
- Boundary cases:
  - shadow=0: raw is constantly 0. pwm_lo asserts DEADTIME cycles after entry, then stays high across wraps.
  - shadow=PERIOD: raw is constantly 1, so there is no transition at wrap and no dead time is inserted.
  - 0 < shadow <= DEADTIME: pwm_hi never asserts. pwm_lo high-time per period = PERIOD-shadow-DEADTIME.
  - General case: pwm_hi width = shadow-DEADTIME; pwm_lo width = PERIOD-shadow-DEADTIME.
  - duty_in changing anywhere except at the load cycle has no effect on the current period.
- period_start: registered, asserted in the cycle after cnt==0 is decoded, i.e. aligned with the outputs.
- duty_applied: reflects shadow, registered; resets to 0.
- Arithmetic: all comparisons are unsigned DW-bit. The min() clamp happens before storage, so shadow <= PERIOD always.

Optional Feature:
- Macro: SWIPT_PWM_SLEW_EN. With it, parameter SLEW (default 50) is added.
- On each load, shadow moves toward the clamped duty_in by at most SLEW counts. The first load after IDLE->RUN still steps from 0.
- clamp_flag semantics are unchanged.
- Without the macro, shadow jumps directly to the clamped value; no SLEW parameter exists.

Decomposition:
- Shared package holds:
  - PWM_PERIOD_DEF = 500 (0x1F4), shared with the duty-adjust stage's ceiling.
  - Default DW=12.
  - State enum {IDLE, RUN}.
- One natural sub-module: swipt_deadtime_ins. It takes raw and the run qualifier and produces pwm_hi/pwm_lo with dt_cnt, so it can be reused per bridge leg.

Test Plan:
- Reset, then en=1, duty_in=250 → pwm_hi high 242 cycles, pwm_lo high 242 cycles, 8-cycle gaps; period_start every 500 cycles.
- duty_in=700 → duty_applied=500, clamp_flag=1, pwm_hi constant 1 after first 8 cycles, pwm_lo never 1.
- duty_in=0 → pwm_lo constant 1 after 8 cycles, no gap at wrap; duty_in=5 → pwm_hi never 1, pwm_lo high 487 cycles/period.
- duty_in toggled 100↔400 every 37 cycles → duty_applied changes only at period boundaries; every pulse width matches the loaded value.
- rst=1 or en=0 at cnt=123 mid-pulse → both outputs 0 on the next edge. On re-enable, the first outputs appear only after 8 cycles, and shadow is reloaded at entry.
- With SWIPT_PWM_SLEW_EN, duty_in 0→300 → duty_applied 50,100,…,300 over 6 periods. The invariant pwm_hi & pwm_lo==0 is asserted throughout all tests.
